// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set constants of the interpolation ASIP, shared by the
// fetch/decode stage, the control unit and the decoder.
//   INSTR_W        instruction width
//   OPC_MSB/LSB    opcode field position (instr[31:27])
//   ALUOP_MSB/LSB  ALU sub-operation field position (instr[2:0])
//   NOP_INSTR      ADD r0,r0,r0 (all-zero word; r0 is hardwired to zero)
//   opcode_e       5-bit major opcodes
package isa_pkg;

  localparam int INSTR_W   = 32;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int ALUOP_MSB = 2;
  localparam int ALUOP_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [4:0] {
    OPC_ALU  = 5'b00000,
    OPC_LD   = 5'b00001,
    OPC_ST   = 5'b00010,
    OPC_BE   = 5'b00100,
    OPC_BGT  = 5'b00101,
    OPC_JMP  = 5'b01000,
    OPC_JR   = 5'b01001,
    OPC_CALL = 5'b01010
  } opcode_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [ALUOP_MSB-ALUOP_LSB:0] get_aluop(input logic [INSTR_W-1:0] instr);
    return instr[ALUOP_MSB:ALUOP_LSB];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register and next-PC mux of the fetch stage.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   hold           keep PC (hazard stall or fetch warm-up)
//   redirect       load word-aligned redirect_pc (wins over hold)
//   redirect_pc    branch/jump target byte address
//   pc             address of the word the ROM returns this cycle
//   pc_next        value loaded into pc at the next edge
module pc_reg
  import isa_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc + PC_W'(4);
    if (redirect) begin
      // Low two bits of the target are dropped: fetch is always word aligned.
      pc_next = redirect_pc & ~PC_W'(3);
    end else if (hold) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF stage plus IF/ID pipeline register of the
// interpolation ASIP. Holds the PC, addresses the synchronous instruction ROM,
// registers the fetched word and splits the opcode/ALU-op fields for ID.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold PC and IF/ID register
//   redirect, redirect_pc    taken branch/jump from EX: load target, flush IF/ID
//   imem_addr, imem_rdata    ROM word address (from next-PC) / data (1-cycle latency)
//   id_instr, id_pc          registered instruction and its PC
//   id_pc_plus4              id_pc+4, CALL link value
//   id_valid                 id_instr is a real instruction, not a bubble
//   id_opcode, id_aluop      instruction fields for the control unit
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt, perf_stall_cnt and
// perf_flush_cnt (32-bit, wrapping, cleared by rst).
module fetch_decode_stage
  import isa_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = isa_pkg::INSTR_W,
  parameter int              IMEM_AW  = 10,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic               id_valid,
  output logic [4:0]         id_opcode,
  output logic [2:0]         id_aluop
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic               fetch_ok;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               vld_p1;
  logic               unused_pc_bits;

  // Until fetch_ok rises the PC is held, so the ROM word addressed during
  // reset is captured (as a bubble) and then re-read for the first real fetch.
  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .hold        (stall | ~fetch_ok),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_next     (pc_next)
  );

  // IF: ROM is addressed with the next PC so its data lines up with pc.
  assign imem_addr      = rst ? RESET_PC[IMEM_AW+1:2] : pc_next[IMEM_AW+1:2];
  assign unused_pc_bits = ^{pc_next[PC_W-1:IMEM_AW+2], pc_next[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ok <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= RESET_PC;
      vld_p1   <= 1'b0;
    end else begin
      fetch_ok <= 1'b1;
      if (redirect) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else if (!stall) begin
        instr_p1 <= imem_rdata;
        pc_p1    <= pc;
        vld_p1   <= fetch_ok;
      end
    end
  end

  // ID: field slices of the IF/ID register.
  assign id_instr    = instr_p1;
  assign id_pc       = pc_p1;
  assign id_valid    = vld_p1;
  assign id_pc_plus4 = pc_p1 + PC_W'(4);
  assign id_opcode   = get_opcode(instr_p1);
  assign id_aluop    = get_aluop(instr_p1);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (redirect) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end else if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else if (fetch_ok) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [2:0]  id_aluop;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:1023];

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  fetch_decode_stage #(
    .PC_W     (32),
    .INSTR_W  (32),
    .IMEM_AW  (10),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_aluop    (id_aluop)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %0h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h want 0", id_pc); end
    checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
`ifdef IF_PERF_CNT_EN
    checks++; if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
      errors++; $display("FAIL reset_perf got %0h/%0h/%0h want 0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
`endif
    rst = 1'b0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_valid got %0h want 0", id_valid); end
    step();
    checks++; if (id_instr !== 32'h100 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
      errors++; $display("FAIL first_fetch got instr=%0h pc=%0h v=%0h want 100/0/1", id_instr, id_pc, id_valid); end
  endtask

  task automatic test_sequential;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++; if (id_instr !== 32'h100 + k || id_pc !== 32'(4 * k) || id_valid !== 1'b1) begin
        errors++; $display("FAIL seq_%0d got instr=%0h pc=%0h v=%0h want %0h/%0h/1", k, id_instr, id_pc, id_valid, 32'h100 + k, 4 * k); end
      checks++; if (id_pc_plus4 !== 32'(4 * k + 4)) begin
        errors++; $display("FAIL seq_plus4_%0d got %0h want %0h", k, id_pc_plus4, 4 * k + 4); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (id_pc !== 32'h8 || id_instr !== 32'h102 || id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got pc=%0h instr=%0h v=%0h want 8/102/1", k, id_pc, id_instr, id_valid); end
      checks++; if (imem_addr !== 10'd3) begin
        errors++; $display("FAIL stall_imem_addr_%0d got %0h want 3", k, imem_addr); end
    end
    stall = 1'b0;
    step();
    checks++; if (id_pc !== 32'hC || id_instr !== 32'h103) begin
      errors++; $display("FAIL stall_resume got pc=%0h instr=%0h want c/103", id_pc, id_instr); end
    step();
    checks++; if (id_pc !== 32'h10 || id_instr !== 32'h104) begin
      errors++; $display("FAIL stall_resume2 got pc=%0h instr=%0h want 10/104", id_pc, id_instr); end
  endtask

  task automatic test_redirect;
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin
      errors++; $display("FAIL redirect_bubble got v=%0h instr=%0h want 0/0", id_valid, id_instr); end
    step();
    checks++; if (id_pc !== 32'h40 || id_instr !== 32'h110 || id_valid !== 1'b1) begin
      errors++; $display("FAIL redirect_target got pc=%0h instr=%0h v=%0h want 40/110/1", id_pc, id_instr, id_valid); end
    step();
    checks++; if (id_pc !== 32'h44 || id_instr !== 32'h111) begin
      errors++; $display("FAIL redirect_next got pc=%0h instr=%0h want 44/111", id_pc, id_instr); end
  endtask

  task automatic test_redirect_stall;
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
    step();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_stall_bubble got v=%0h want 0", id_valid); end
    step();
    checks++; if (id_pc !== 32'h20 || id_instr !== 32'h108 || id_valid !== 1'b1) begin
      errors++; $display("FAIL redir_stall_target got pc=%0h instr=%0h v=%0h want 20/108/1", id_pc, id_instr, id_valid); end
  endtask

  task automatic test_decode_align;
    rom[8] = 32'hC000_0005;
    redirect = 1'b1; redirect_pc = 32'h23;
    step();
    redirect = 1'b0;
    step();
    checks++; if (id_pc !== 32'h20 || id_instr !== 32'hC000_0005) begin
      errors++; $display("FAIL align_fetch got pc=%0h instr=%0h want 20/c0000005", id_pc, id_instr); end
    checks++; if (id_opcode !== 5'b11000 || id_aluop !== 3'b101) begin
      errors++; $display("FAIL decode_fields got opc=%0b aluop=%0b want 11000/101", id_opcode, id_aluop); end
    checks++; if (id_pc_plus4 !== 32'h24) begin
      errors++; $display("FAIL decode_plus4 got %0h want 24", id_pc_plus4); end
  endtask

  task automatic test_reset_mid;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
      errors++; $display("FAIL midrst_state got v=%0h pc=%0h instr=%0h want 0/0/0", id_valid, id_pc, id_instr); end
`ifdef IF_PERF_CNT_EN
    checks++; if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
      errors++; $display("FAIL midrst_perf got %0h/%0h/%0h want 0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
`endif
    step();
    checks++; if (id_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_warmup got v=%0h want 0", id_valid); end
    step();
    checks++; if (id_pc !== 32'h0 || id_instr !== 32'h100 || id_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_restart got pc=%0h instr=%0h v=%0h want 0/100/1", id_pc, id_instr, id_valid); end
    step();
    checks++; if (id_pc !== 32'h4 || id_instr !== 32'h101) begin
      errors++; $display("FAIL midrst_next got pc=%0h instr=%0h want 4/101", id_pc, id_instr); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h100 + 32'(i);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_decode_align();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
